// File: rtl/vga_fetch_sched_if.sv
// Handshake and data bundle between the CRTC/sequencer fetch stage
// and the PAL/DAC stage.
interface vga_fetch_sched_if #(
    parameter int DW = 12,
    parameter int AW = 3
);
    logic          csr_stb_i;
    logic          csr_ack_i;
    logic [DW-1:0] seq_data_i;
    logic          enable_crtc_o;
    logic          enable_sequencer_o;
    logic          enable_pal_dac_o;
    logic [DW-1:0] pal_data_o;
    logic [AW:0]   fifo_level_o;
    logic          underrun_o;

    modport master (
        output csr_stb_i, csr_ack_i, seq_data_i,
        input  enable_crtc_o, enable_sequencer_o, enable_pal_dac_o,
        input  pal_data_o, fifo_level_o, underrun_o
    );

    modport slave (
        input  csr_stb_i, csr_ack_i, seq_data_i,
        output enable_crtc_o, enable_sequencer_o, enable_pal_dac_o,
        output pal_data_o, fifo_level_o, underrun_o
    );
endinterface

// File: rtl/vga_fetch_sched.sv
// Pacing controller: buffers sequencer bundles in a small FIFO and
// releases one to the PAL/DAC stage per pixel tick (clk/DIV).
module vga_fetch_sched #(
    parameter int DW    = 12,
    parameter int AW    = 3,
    parameter int DIV   = 4,
    parameter int PRIME = 4
) (
    input logic              clk,
    input logic              rst,
    vga_fetch_sched_if.slave bus
);
    localparam int DEPTH = 2 ** AW;
    localparam int CW    = $clog2(DIV);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   PRIME_L = (AW + 1)'(PRIME);
    localparam logic [CW-1:0] LAST    = CW'(DIV - 1);

    typedef enum logic {FILL, RUN} state_t;

    state_t        state;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic [AW:0]   level_next;
    logic [CW-1:0] cnt;
    logic [DW-1:0] pal_data_q;
    logic          pal_en_q;
    logic          underrun_q;
    logic          tick;
    logic          mem_wait;
    logic          pop;
    logic          push;

    assign mem_wait   = bus.csr_stb_i & ~bus.csr_ack_i;
    assign tick       = (cnt == LAST);
    assign pop        = tick & (state == RUN) & (level != '0);
    assign push       = ~rst & ~mem_wait & ((level < DEPTH_L) | pop);
    assign level_next = level + (AW + 1)'(push) - (AW + 1)'(pop);

    assign bus.enable_crtc_o      = push;
    assign bus.enable_sequencer_o = push;
    assign bus.enable_pal_dac_o   = pal_en_q;
    assign bus.pal_data_o         = pal_data_q;
    assign bus.fifo_level_o       = level;
    assign bus.underrun_o         = underrun_q;

    // FIFO storage: written on every upstream enable, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.seq_data_i;
        end
    end

    // Tick counter, pointers, level and FILL/RUN pacing FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            cnt        <= '0;
            pal_data_q <= '0;
            pal_en_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt      <= tick ? '0 : cnt + 1'b1;
            level    <= level_next;
            pal_en_q <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case (state)
                FILL: begin
                    if (level_next >= PRIME_L) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (tick) begin
                        pal_en_q <= 1'b1;
                        if (level != '0) begin
                            pal_data_q <= mem[rd_ptr];
                        end else begin
                            // Blank the line rather than repeat stale pixels
                            pal_data_q[9:8] <= 2'b00;
                            underrun_q      <= 1'b1;
                            state           <= FILL;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_fetch_sched.sv
// Self-checking bench for vga_fetch_sched: directed phases with random
// data against a queue-based reference model of the pacing rules.
module tb_vga_fetch_sched;
    localparam int DW    = 12;
    localparam int AW    = 3;
    localparam int DIV   = 4;
    localparam int PRIME = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_fetch_sched_if #(.DW(DW), .AW(AW)) bus ();

    vga_fetch_sched #(
        .DW(DW), .AW(AW), .DIV(DIV), .PRIME(PRIME)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    // reference model state
    logic [DW-1:0] q[$];
    int            phase    = 0;
    bit            running  = 0;
    logic [DW-1:0] m_data   = '0;
    bit            m_en     = 0;
    bit            m_underr = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit stb, input bit ack,
                        input logic [DW-1:0] d);
        bit tick_now, pop_now, en_now, was_run;
        @(negedge clk);
        rst            = r;
        bus.csr_stb_i  = stb;
        bus.csr_ack_i  = ack;
        bus.seq_data_i = d;
        #1;
        tick_now = (phase == DIV - 1);
        pop_now  = running && tick_now && (q.size() != 0);
        en_now   = !r && !(stb && !ack) && ((q.size() < DEPTH) || pop_now);
        chk("enable_crtc", 32'(bus.enable_crtc_o), 32'(en_now));
        chk("enable_seq", 32'(bus.enable_sequencer_o), 32'(en_now));
        chk("fifo_level", 32'(bus.fifo_level_o), 32'(q.size()));
        @(posedge clk);
        if (r) begin
            q.delete();
            phase    = 0;
            running  = 0;
            m_data   = '0;
            m_en     = 0;
            m_underr = 0;
        end else begin
            was_run = running;
            m_en    = 0;
            phase   = (phase + 1) % DIV;
            if (was_run && tick_now) begin
                m_en = 1;
                if (q.size() != 0) begin
                    m_data = q.pop_front();
                end else begin
                    m_data[9:8] = 2'b00;
                    m_underr    = 1;
                    running     = 0;
                end
            end
            if (en_now) q.push_back(d);
            if (!was_run && q.size() >= PRIME) running = 1;
        end
        #1;
        if (bus.enable_pal_dac_o === 1'b1) pulses++;
        chk("pal_en", 32'(bus.enable_pal_dac_o), 32'(m_en));
        chk("pal_data", 32'(bus.pal_data_o), 32'(m_data));
        chk("underrun", 32'(bus.underrun_o), 32'(m_underr));
    endtask

    logic [DW-1:0] first_word;
    logic [DW-1:0] seq;
    bit            seen_first;

    initial begin
        bus.csr_stb_i  = 1'b0;
        bus.csr_ack_i  = 1'b1;
        bus.seq_data_i = '0;
        seen_first     = 0;

        // reset
        for (int i = 0; i < 3; i++) step(1, 0, 1, 12'($urandom));

        // priming: first pulse carries first pushed bundle
        first_word = 12'($urandom);
        step(0, 0, 1, first_word);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, 12'($urandom));
            if (!seen_first && bus.enable_pal_dac_o === 1'b1) begin
                seen_first = 1;
                chk("t2_first_data", 32'(bus.pal_data_o), 32'(first_word));
            end
        end
        chk("t2_first_seen", 32'(seen_first), 32'd1);

        // steady state with counting data, covers full push+pop and wrap
        seq    = 12'h100;
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            step(0, 0, 1, seq);
            seq = seq + 1'b1;
        end
        chk("t3_duty", 32'(pulses), 32'd250);
        chk("t3_level", 32'(bus.fifo_level_o), 32'd8);

        // memory wait: drain to underrun
        for (int i = 0; i < 40; i++) step(0, 1, 0, 12'($urandom));
        chk("t4_underrun", 32'(bus.underrun_o), 32'd1);
        chk("t4_von", 32'(bus.pal_data_o[9:8]), 32'd0);
        chk("t4_level", 32'(bus.fifo_level_o), 32'd0);

        // random traffic
        for (int i = 0; i < 2000; i++)
            step(0, 1'($urandom), 1'($urandom_range(0, 3) != 0),
                 12'($urandom));

        // mid-stream reset, then random traffic with heavier stalls
        for (int i = 0; i < 3; i++) step(1, 1'($urandom), 1, 12'($urandom));
        step(0, 0, 1, 12'($urandom));
        chk("t1_underrun_clr", 32'(bus.underrun_o), 32'd0);
        for (int i = 0; i < 2000; i++)
            step(0, 1'($urandom), 1'($urandom_range(0, 2) == 0),
                 12'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
